// File: rtl/main_memory.sv
// Single-port main memory behind the MMU: one word access at a time with a fixed access latency.
// Optional per-byte write enables are compiled in with `define MAIN_MEMORY_BYTE_ENABLE_EN.
module main_memory #(
  parameter int ADDR_WIDTH  = 32,
  parameter int DATA_WIDTH  = 32,
  parameter int DEPTH_WORDS = 1024,
  parameter int LATENCY     = 4
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [ADDR_WIDTH-1:0] address,
  input  logic                  read,
  input  logic                  write,
  input  logic [DATA_WIDTH-1:0] wdata,
`ifdef MAIN_MEMORY_BYTE_ENABLE_EN
  input  logic [3:0]            byte_enable,
`endif
  output logic [DATA_WIDTH-1:0] rdata,
  output logic                  ready,
  output logic                  done,
  output logic                  busy
);

  localparam int IDX_W = $clog2(DEPTH_WORDS);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_WAIT = 2'd1;
  localparam logic [1:0] ST_RESP = 2'd2;

  localparam logic KIND_RD = 1'b0;
  localparam logic KIND_WR = 1'b1;

  localparam logic [3:0] CNT_LOAD = 4'(LATENCY - 1);

  logic [1:0]            state;
  logic [3:0]            count;
  logic                  kind;
  logic [IDX_W-1:0]      idx;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic [DATA_WIDTH-1:0] mem [DEPTH_WORDS];
  logic [IDX_W-1:0]      addr_idx;
  logic                  req_held;
  logic                  commit_wr;
  logic                  unused_addr_bits;

  // Byte-offset bits and index bits above the array are dropped, so the address wraps.
  assign addr_idx         = address[IDX_W+1:2];
  assign unused_addr_bits = ^{address[ADDR_WIDTH-1:IDX_W+2], address[1:0]};

  // The request line that must stay high for the accepted access to proceed.
  assign req_held  = (kind == KIND_WR) ? write : read;
  assign commit_wr = (state == ST_WAIT) && (kind == KIND_WR) && write && (count == 4'd0);
  assign busy      = (state != ST_IDLE);

`ifdef MAIN_MEMORY_BYTE_ENABLE_EN
  logic [3:0] be_q;
`endif

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state   <= ST_IDLE;
      count   <= 4'd0;
      kind    <= KIND_RD;
      idx     <= '0;
      wdata_q <= '0;
      rdata   <= '0;
      ready   <= 1'b0;
      done    <= 1'b0;
`ifdef MAIN_MEMORY_BYTE_ENABLE_EN
      be_q    <= 4'd0;
`endif
    end else begin
      case (state)
        ST_IDLE: begin
          if (write) begin
            idx     <= addr_idx;
            wdata_q <= wdata;
            kind    <= KIND_WR;
            count   <= CNT_LOAD;
            state   <= ST_WAIT;
`ifdef MAIN_MEMORY_BYTE_ENABLE_EN
            be_q    <= byte_enable;
`endif
          end else if (read) begin
            idx   <= addr_idx;
            kind  <= KIND_RD;
            count <= CNT_LOAD;
            state <= ST_WAIT;
          end
        end

        ST_WAIT: begin
          if (!req_held) begin
            count <= 4'd0;
            state <= ST_IDLE;
          end else if (count == 4'd0) begin
            state <= ST_RESP;
            if (kind == KIND_RD) begin
              rdata <= mem[idx];
              ready <= 1'b1;
            end else begin
              done <= 1'b1;
            end
          end else begin
            count <= count - 4'd1;
          end
        end

        ST_RESP: begin
          // Outputs hold until the MMU withdraws the request; the next request waits one more edge.
          if (!req_held) begin
            rdata <= '0;
            ready <= 1'b0;
            done  <= 1'b0;
            state <= ST_IDLE;
          end
        end

        default: state <= ST_IDLE;
      endcase
    end
  end

  // NOTE: the array has no reset so it maps onto RAM; reset only gates off the write.
  always_ff @(posedge clock) begin
    if (!reset && commit_wr) begin
`ifdef MAIN_MEMORY_BYTE_ENABLE_EN
      for (int b = 0; b < 4; b++) begin
        if (be_q[b]) mem[idx][8*b +: 8] <= wdata_q[8*b +: 8];
      end
`else
      mem[idx] <= wdata_q;
`endif
    end
  end

endmodule
